vga_sync_rx: RTL and testbench
==============================

# vga_sync_rx

Receive-side timing recovery for the VGA stream produced by our VGA timing generator. The block watches hsync, vsync and data-enable on the system clock, locks onto the 800×525 / 640×480 frame structure, and reports pixel coordinates, frame boundaries, lock status and timing errors. It sits on the output side of the display path as a self-check and capture front end, feeding on-board loopback tests and the frame-capture logic.

## Interface
- CLK_PER_PIX, 4: clk cycles per pixel (power of two, ≥2)
- H_TOTAL, 800: pixels per line
- H_SYNC, 96: hsync low width, pixels
- H_ACT_BEGIN, 144: first active pixel, line-relative
- H_ACT, 640: active pixels per line
- V_TOTAL, 525: lines per frame
- V_SYNC, 2: vsync low width, lines
- V_ACT_BEGIN, 35: first active line, frame-relative
- V_ACT, 480: active lines per frame

- clk  input  1  system clock; all inputs synchronous to it
- reset  input  1  asynchronous, active-low reset
- hsync_in  input  1  horizontal sync, active low, each level held a multiple of CLK_PER_PIX
- vsync_in  input  1  vertical sync, active low
- de_in  input  1  transmitter data-enable
- pix_stb  output  1  one-clk strobe per active pixel while locked
- pix_x  output  10  active-region column, 0..H_ACT-1
- pix_y  output  10  active-region row, 0..V_ACT-1
- frame_stb  output  1  one-clk strobe at start of each frame while locked
- locked  output  1  timing lock
- de_err  output  1  one-clk pulse on de_in mismatch while locked
- err_cnt  output  8  saturating count of lock losses

## Operation
- Inputs registered once (r1), then delayed once (r2). hs_fall = r2 & ~r1; hs_rise = ~r2 & r1; same for vsync.
- Counters: phase (log2 CLK_PER_PIX bits), h_cnt (10 bit), v_cnt (10 bit).
  - Cycle with hs_fall is phase 0 of pixel h=0: h_cnt←0, phase←1.
  - Otherwise phase increments mod CLK_PER_PIX; on wrap to 0, h_cnt increments.
  - On hs_fall: v_cnt←0 if vs_fall in the same cycle, else v_cnt+1.
  - vs_fall without coincident hs_fall is a frame error.
- Checks (only in ACQUIRE/LOCKED):
  - line_err: hs_fall with (h_cnt≠H_TOTAL or phase≠0).
  - hw_err: hs_rise with (h_cnt≠H_SYNC or phase≠0).
  - vw_err: vs_rise on a line with v_cnt≠V_SYNC, or not at hs_fall.
  - frame_err: vs_fall at hs_fall with previous v_cnt≠V_TOTAL-1, or v_cnt reaching V_TOTAL.
- FSM:
  - SEARCH: counters run, no checks. vs_fall coincident with hs_fall → ACQUIRE.
  - ACQUIRE: any error → SEARCH. Next vs_fall with no error in the frame → LOCKED.
  - LOCKED: any error → SEARCH, err_cnt+1 (saturates at 255).
- Active window: H_ACT_BEGIN ≤ h_cnt < H_ACT_BEGIN+H_ACT and V_ACT_BEGIN ≤ v_cnt < V_ACT_BEGIN+V_ACT.
- Per pixel, at phase 0 in LOCKED inside the window:
  - pix_stb=1, pix_x=h_cnt−H_ACT_BEGIN, pix_y=v_cnt−V_ACT_BEGIN.
  - pix_x/pix_y hold their values between strobes.
- de_err pulses when, at phase 0 in LOCKED, de_in (r1) ≠ window. Lock is kept.
- frame_stb pulses on vs_fall while LOCKED. It also pulses on the ACQUIRE→LOCKED transition.

## Timing
- Reset: all outputs 0, FSM SEARCH, all counters 0.
- Reset asserted mid-frame clears everything immediately. Relock requires a fresh vs_fall plus one clean frame.
- Latency: a pixel whose inputs are first presented in clk cycle T gets pix_stb in cycle T+2. frame_stb has the same 2-clk latency from the raw vsync edge.
- locked:
  - Deasserts in the cycle after the erroring edge is detected. pix_stb stops that same cycle.
  - Asserts the cycle after the qualifying vs_fall. The first pix_stb after that is pixel (0,0).
- If errors coincide with a vs_fall, the error wins: FSM goes to SEARCH, not LOCKED.
- If vs_fall and hs_fall coincide in SEARCH, that cycle starts ACQUIRE and line 0.
- err_cnt holds at 255 and clears only on reset.

## Test plan
- Nominal 640×480, CLK_PER_PIX=4, generator stream from reset → ACQUIRE after the first vs_fall, locked=1 after the second. Then exactly 307200 pix_stb per frame, first (0,0), last (639,479), and one frame_stb per 1,680,000 clk.
- While locked, one line stretched to 801 pixels → locked=0 at that line's hs_fall+1, err_cnt=1, no pix_stb until relock two vs_falls later.
- While locked, hsync low width 95 pixels → hw_err, locked drops, err_cnt increments.
- While locked, de_in forced low for pixel (10,20) → single de_err pulse, locked stays 1, pix_stb count unchanged.
- reset low for 3 clk mid-frame → all outputs 0 asynchronously; locked returns after next vs_fall plus one full clean frame.
- 300 consecutive induced lock losses → err_cnt saturates at 255.

Source files
------------

// File: rtl/vga_sync_rx.sv
// VGA receive-side timing recovery: locks to hsync/vsync/de and reports
// pixel coordinates, frame starts, lock state and timing errors.
module vga_sync_rx #(
    parameter int CLK_PER_PIX = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_BEGIN = 144,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_BEGIN = 35,
    parameter int V_ACT       = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       de_in,
    output logic       pix_stb,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_stb,
    output logic       locked,
    output logic       de_err,
    output logic [7:0] err_cnt
);

    localparam int PW = $clog2(CLK_PER_PIX);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_PIX - 1);
    localparam logic [9:0] HT    = 10'(H_TOTAL);
    localparam logic [9:0] HSW   = 10'(H_SYNC);
    localparam logic [9:0] HB    = 10'(H_ACT_BEGIN);
    localparam logic [9:0] HE    = 10'(H_ACT_BEGIN + H_ACT);
    localparam logic [9:0] VT    = 10'(V_TOTAL);
    localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
    localparam logic [9:0] VSW   = 10'(V_SYNC);
    localparam logic [9:0] VB    = 10'(V_ACT_BEGIN);
    localparam logic [9:0] VE    = 10'(V_ACT_BEGIN + V_ACT);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t        state, state_n;
    logic          hs1, hs2, vs1, vs2, de1;
    logic [PW-1:0] phase, cur_ph, phase_n;
    logic [9:0]    h_cnt, v_cnt, cur_h, cur_v, h_n, v_inc;
    logic          hs_fall, hs_rise, vs_fall, vs_rise;
    logic          line_err, hw_err, vw_err, frame_err, err;
    logic          in_win, run, stb_n, de_err_n, frame_n;

    assign hs_fall = hs2 & ~hs1;
    assign hs_rise = ~hs2 & hs1;
    assign vs_fall = vs2 & ~vs1;
    assign vs_rise = ~vs2 & vs1;

    // Registers hold the position of the current cycle, except on the
    // hs_fall cycle, which is by definition phase 0 of pixel 0.
    assign v_inc   = v_cnt + 10'd1;
    assign cur_ph  = hs_fall ? '0 : phase;
    assign cur_h   = hs_fall ? '0 : h_cnt;
    assign cur_v   = hs_fall ? (vs_fall ? '0 : v_inc) : v_cnt;
    assign phase_n = cur_ph + 1'b1;
    assign h_n     = (cur_ph == PH_LAST) ? cur_h + 10'd1 : cur_h;

    assign line_err  = hs_fall && (h_cnt != HT || phase != '0);
    assign hw_err    = hs_rise && (h_cnt != HSW || phase != '0);
    assign vw_err    = vs_rise && (!hs_fall || cur_v != VSW);
    assign frame_err = (vs_fall && (!hs_fall || v_cnt != VT_M1))
                     || (hs_fall && !vs_fall && v_inc == VT);
    assign err = (state != SEARCH)
               && (line_err || hw_err || vw_err || frame_err);

    always_comb begin
        state_n = state;
        case (state)
            SEARCH:  if (vs_fall && hs_fall) state_n = ACQUIRE;
            ACQUIRE: begin
                if (err)          state_n = SEARCH;
                else if (vs_fall) state_n = LOCKED;
            end
            LOCKED:  if (err) state_n = SEARCH;
            default: state_n = SEARCH;
        endcase
    end

    assign in_win   = cur_h >= HB && cur_h < HE && cur_v >= VB && cur_v < VE;
    assign run      = state == LOCKED && !err && cur_ph == '0;
    assign stb_n    = run && in_win;
    assign de_err_n = run && (de1 != in_win);
    assign frame_n  = vs_fall && state_n == LOCKED;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs1       <= 1'b0;
            hs2       <= 1'b0;
            vs1       <= 1'b0;
            vs2       <= 1'b0;
            de1       <= 1'b0;
            phase     <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            state     <= SEARCH;
            pix_stb   <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            frame_stb <= 1'b0;
            locked    <= 1'b0;
            de_err    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            hs1       <= hsync_in;
            hs2       <= hs1;
            vs1       <= vsync_in;
            vs2       <= vs1;
            de1       <= de_in;
            phase     <= phase_n;
            h_cnt     <= h_n;
            v_cnt     <= cur_v;
            state     <= state_n;
            locked    <= state_n == LOCKED;
            pix_stb   <= stb_n;
            frame_stb <= frame_n;
            de_err    <= de_err_n;
            if (stb_n) begin
                pix_x <= cur_h - HB;
                pix_y <= cur_v - VB;
            end
            if (state == LOCKED && err && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx on a reduced 10x8 frame so that
// lock, relock, reset and saturation all fit in a short run.
module tb_vga_sync_rx;

    localparam int CPP = 2;
    localparam int HT  = 10;
    localparam int HS  = 2;
    localparam int HB  = 3;
    localparam int HA  = 6;
    localparam int VT  = 8;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int VA  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       de_in = 1'b0;
    logic       pix_stb, frame_stb, locked, de_err;
    logic [9:0] pix_x, pix_y;
    logic [7:0] err_cnt;

    vga_sync_rx #(
        .CLK_PER_PIX(CPP), .H_TOTAL(HT), .H_SYNC(HS),
        .H_ACT_BEGIN(HB), .H_ACT(HA), .V_TOTAL(VT),
        .V_SYNC(VS), .V_ACT_BEGIN(VB), .V_ACT(VA)
    ) dut (
        .clk(clk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .pix_stb(pix_stb), .pix_x(pix_x), .pix_y(pix_y),
        .frame_stb(frame_stb), .locked(locked),
        .de_err(de_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int t; int x; int y;} pix_t;
    pix_t exp_pix[$];
    int   exp_frm[$];

    int checks = 0;
    int errors = 0;
    int mst = 0;
    int exp_errs = 0;
    int exp_de = 0;
    int got_de = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes.
    always @(negedge clk) begin
        pix_t p;
        if (pix_stb) begin
            chk("pix_pending", int'(exp_pix.size() > 0), 1);
            if (exp_pix.size() > 0) begin
                p = exp_pix.pop_front();
                chk("pix_time", cyc, p.t);
                chk("pix_x", int'(pix_x), p.x);
                chk("pix_y", int'(pix_y), p.y);
            end
        end
        if (frame_stb) begin
            chk("frm_pending", int'(exp_frm.size() > 0), 1);
            if (exp_frm.size() > 0)
                chk("frm_time", cyc, exp_frm.pop_front());
        end
        if (de_err) got_de <= got_de + 1;
    end

    task automatic lose();
        if (mst == 2 && exp_errs < 255) exp_errs++;
        mst = 0;
    endtask

    task automatic send_line(input int v, input int hlen, input int hsw,
                             input bit vlow, input int dx, input int dy,
                             input bit fs);
        bit win, drop;
        for (int h = 0; h < hlen; h++) begin
            for (int p = 0; p < CPP; p++) begin
                @(negedge clk);
                win  = h >= HB && h < HB + HA && v >= VB && v < VB + VA;
                drop = win && (h - HB) == dx && (v - VB) == dy;
                hsync_in = !(h < hsw);
                vsync_in = !vlow;
                de_in    = win && !drop;
                if (h == 0 && p == 0 && fs) exp_frm.push_back(cyc + 2);
                if (p == 0 && mst == 2) begin
                    if (win) exp_pix.push_back('{cyc + 2, h - HB, v - VB});
                    if (drop) exp_de++;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        exp_pix.delete();
        exp_frm.delete();
        mst = 0;
        exp_errs = 0;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_pix_x", int'(pix_x), 0);
        chk("rst_pix_y", int'(pix_y), 0);
        chk("rst_pix_stb", int'(pix_stb), 0);
        chk("rst_frame_stb", int'(frame_stb), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic send_frame(input int nl, input int stretch_v,
                              input int short_v, input int dx,
                              input int dy, input int rst_v);
        bit fs;
        fs = 1'b0;
        if (mst == 0) mst = 1;
        else begin
            mst = 2;
            fs  = 1'b1;
        end
        for (int v = 0; v < nl; v++) begin
            if (v > 0 && v - 1 == stretch_v) lose();
            if (v == short_v) lose();
            if (nl < VT && v == 1) lose();
            if (v == rst_v) do_reset();
            send_line(v, (v == stretch_v) ? HT + 1 : HT,
                      (v == short_v) ? HS - 1 : HS,
                      v < ((nl < VT) ? 1 : VS), dx, dy, v == 0 && fs);
        end
    endtask

    task automatic checkpoint(input string tag, input bit lk);
        chk({tag, "_locked"}, int'(locked), int'(lk));
        chk({tag, "_err_cnt"}, int'(err_cnt), exp_errs);
        chk({tag, "_pix_left"}, exp_pix.size(), 0);
        chk({tag, "_frm_left"}, exp_frm.size(), 0);
        chk({tag, "_de_err"}, got_de, exp_de);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("init_locked", int'(locked), 0);
        chk("init_err_cnt", int'(err_cnt), 0);
        chk("init_pix_stb", int'(pix_stb), 0);
        chk("init_frame_stb", int'(frame_stb), 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(VT, -1, -1, -1, -1, -1);
        checkpoint("acquire", 1'b0);
        send_frame(VT, -1, -1, -1, -1, -1);
        checkpoint("lock1", 1'b1);
        send_frame(VT, -1, -1, 2, 1, -1);
        checkpoint("de_drop", 1'b1);

        send_frame(VT, 4, -1, -1, -1, -1);
        checkpoint("stretch", 1'b0);
        chk("stretch_cnt", int'(err_cnt), 1);
        send_frame(VT, -1, -1, -1, -1, -1);
        checkpoint("relock_acq", 1'b0);
        send_frame(VT, -1, -1, -1, -1, -1);
        checkpoint("relock", 1'b1);

        send_frame(VT, -1, 4, -1, -1, -1);
        checkpoint("short_hs", 1'b0);
        chk("short_hs_cnt", int'(err_cnt), 2);
        send_frame(VT, -1, -1, -1, -1, -1);
        send_frame(VT, -1, -1, -1, -1, -1);
        checkpoint("relock2", 1'b1);

        send_frame(VT, -1, -1, -1, -1, 4);
        checkpoint("post_reset", 1'b0);
        send_frame(VT, -1, -1, -1, -1, -1);
        checkpoint("reset_acq", 1'b0);
        send_frame(VT, -1, -1, -1, -1, -1);
        checkpoint("reset_relock", 1'b1);

        for (int i = 0; i < 260; i++) begin
            send_frame(2, -1, -1, -1, -1, -1);
            send_frame(VT, -1, -1, -1, -1, -1);
            if (i % 64 == 63) chk("sat_progress", int'(err_cnt), exp_errs);
        end
        send_frame(VT, -1, -1, -1, -1, -1);
        checkpoint("saturated", 1'b1);
        chk("sat_value", int'(err_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
